// File: rtl/aes_pkg.sv
// AES byte substitution tables and lookup helper.
// Shared by the SubBytes pipe and key expansion.
package aes_pkg;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  function automatic logic [7:0] sbox_sub(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Single-byte forward/inverse S-box lookup.
// Inverse table drops out when SUPPORT_INV is 0.
module aes_sbox_lut
  import aes_pkg::*;
#(
  parameter int SUPPORT_INV = 1
) (
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  always_comb begin
    out = sbox_sub(in, (SUPPORT_INV != 0) && inv);
  end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Multi-lane SubBytes/InvSubBytes with an elastic
// valid/ready register pipeline.
module aes_sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int SUPPORT_INV = 1,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int DW = 8 * LANES;
  localparam int LS = PIPE_STAGES - 1;

  logic          inv_eff;
  logic [DW-1:0] sub;

  assign inv_eff = (SUPPORT_INV != 0) && in_inv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_sbox_lut #(
      .SUPPORT_INV(SUPPORT_INV)
    ) u_lut (
      .in (in_data[8*k +: 8]),
      .inv(inv_eff),
      .out(sub[8*k +: 8])
    );
  end

  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES:0]   rdy;
  logic [PIPE_STAGES-1:0] up_v;
  logic [PIPE_STAGES-1:0] iq;
  logic [PIPE_STAGES-1:0] si;
  logic [DW-1:0]          dq [PIPE_STAGES];
  logic [DW-1:0]          sd [PIPE_STAGES];
  logic [TAG_W-1:0]       tq [PIPE_STAGES];
  logic [TAG_W-1:0]       st [PIPE_STAGES];

  // Ready ripples back from the output so a full pipe still
  // accepts when the last stage drains.
  always_comb begin
    rdy = '0;
    rdy[PIPE_STAGES] = out_ready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  assign in_ready = rdy[0] && !flush;

  always_comb begin
    up_v    = '0;
    si      = '0;
    up_v[0] = in_valid && !flush;
    sd[0]   = sub;
    si[0]   = inv_eff;
    st[0]   = in_tag;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      up_v[i] = vld[i-1];
      sd[i]   = dq[i-1];
      si[i]   = iq[i-1];
      st[i]   = tq[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      iq  <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        dq[i] <= '0;
        tq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (flush) begin
          vld[i] <= 1'b0;
        end else if (rdy[i]) begin
          vld[i] <= up_v[i];
        end
        if (up_v[i] && rdy[i]) begin
          dq[i] <= sd[i];
          iq[i] <= si[i];
          tq[i] <= st[i];
        end
      end
    end
  end

  assign out_valid = vld[LS];
  assign out_data  = dq[LS];
  assign out_inv   = iq[LS];
  assign out_tag   = tq[LS];
  assign busy      = |vld;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Directed bench for aes_sub_bytes_pipe: latency, modes,
// backpressure, flush, async reset and full-table sweep.
module tb_aes_sub_bytes_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_inv = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_inv;
  logic [3:0]  out_tag;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] fm [256];
  logic [7:0] im [256];

  aes_sub_bytes_pipe #(
    .LANES(4), .PIPE_STAGES(2), .SUPPORT_INV(1), .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] o,
                     input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", n, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // GF(2^8) multiply, AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] model(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int l = 0; l < 4; l++)
      r[8*l +: 8] = inv ? im[d[8*l +: 8]] : fm[d[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] pat(input int k);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'((k * 37 + l * 11) % 256);
    return r;
  endfunction

  task automatic send_one(input logic [31:0] d, input logic inv,
                          input logic [3:0] t, output logic [31:0] od,
                          output logic oi, output logic [3:0] ot);
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    in_inv = inv;
    in_tag = t;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      tick();
      n++;
    end
    if (!out_valid) chk("send_timeout", 64'(out_valid), 64'd1);
    od = out_data;
    oi = out_inv;
    ot = out_tag;
    tick();
  endtask

  initial begin
    logic [31:0] od, od2, e;
    logic oi;
    logic [3:0] ot;
    logic [7:0] iv;
    int sent, got, ocyc [10];
    bit acc;

    for (int x = 0; x < 256; x++) begin
      iv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      fm[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3)
              ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) im[fm[x]] = 8'(x);

    // reset held with a beat offered
    in_valid = 1'b1;
    in_data = 32'hdeadbeef;
    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // forward vector with latency check
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0053ff01;
    in_inv = 1'b0;
    in_tag = 4'd3;
    #1;
    chk("fwd_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("fwd_lat1_valid", 64'(out_valid), 64'd0);
    chk("fwd_lat1_busy", 64'(busy), 64'd1);
    tick();
    chk("fwd_lat2_valid", 64'(out_valid), 64'd1);
    chk("fwd_data", 64'(out_data), 64'h63ed167c);
    chk("fwd_tag", 64'(out_tag), 64'd3);
    chk("fwd_inv", 64'(out_inv), 64'd0);
    tick();
    chk("fwd_drained", 64'(busy), 64'd0);

    // inverse vectors
    send_one(32'h63ed167c, 1'b1, 4'd5, od, oi, ot);
    chk("inv_data", 64'(od), 64'h0053ff01);
    chk("inv_inv", 64'(oi), 64'd1);
    chk("inv_tag", 64'(ot), 64'd5);
    send_one(32'h52005200, 1'b0, 4'd6, od, oi, ot);
    chk("fwd_52", 64'(od), 64'h00630063);
    send_one(32'h00000000, 1'b1, 4'd7, od, oi, ot);
    chk("inv_00", 64'(od), 64'h52525252);

    // backpressure: out_ready low for cycles 3..8
    sent = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      in_valid = (sent < 10);
      in_data = pat(sent);
      in_inv = 1'b0;
      in_tag = 4'(sent);
      #1;
      if (c >= 3 && c <= 8) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        chk("bp_tag", 64'(out_tag), 64'(got));
        chk("bp_data", 64'(out_data), 64'(model(pat(got), 1'b0)));
        ocyc[got] = c;
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd10);
    chk("bp_resume_cycle", 64'(ocyc[1]), 64'd9);
    for (int k = 2; k < 10; k++)
      chk("bp_no_gap", 64'(ocyc[k]), 64'(ocyc[k-1] + 1));

    // alternating mode, back to back
    out_ready = 1'b1;
    sent = 0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (sent < 4);
      in_data = 32'h0053ff01;
      in_inv = sent[0];
      in_tag = 4'(sent);
      #1;
      if (out_valid) begin
        e = out_tag[0] ? 32'h52507d09 : 32'h63ed167c;
        chk("alt_tag", 64'(out_tag), 64'(got));
        chk("alt_data", 64'(out_data), 64'(e));
        chk("alt_inv", 64'(out_inv), 64'(got % 2));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("alt_count", 64'(got), 64'd4);

    // flush with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11223344;
    in_tag = 4'ha;
    tick();
    in_tag = 4'hb;
    tick();
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    in_tag = 4'hf;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fl_quiet", 64'(out_valid), 64'd0);
    end

    // async reset mid-stream, output stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0053ff01;
    in_tag = 4'h9;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // sweep all bytes both modes, plus round trip
    for (int b = 0; b < 64; b++) begin
      e = {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
      send_one(e, 1'b0, 4'(b), od, oi, ot);
      chk("sw_fwd", 64'(od), 64'(model(e, 1'b0)));
      send_one(od, 1'b1, 4'(b), od2, oi, ot);
      chk("sw_round", 64'(od2), 64'(e));
      send_one(e, 1'b1, 4'(b), od, oi, ot);
      chk("sw_inv", 64'(od), 64'(model(e, 1'b1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("FAIL global_timeout observed=running expected=done");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
